// File: rtl/even_mult_pkg.sv
// Shared types for the even multiplier driver slice.
//   DATA_W   : default result width of the multiplier core
//   result_t : one core result word
//   state_t  : driver FSM states
package even_mult_pkg;

  localparam int unsigned DATA_W = 16;

  typedef logic [DATA_W-1:0] result_t;

  typedef enum logic [2:0] {
    IDLE,
    GO,
    WAIT,
    STORE,
    FINISH
  } state_t;

endpackage

// File: rtl/even_mult_rfifo.sv
// Synchronous result FIFO, DATA_W x DEPTH.
//   clk, reset : rising-edge clock, synchronous active-high reset (empties queue)
//   push, din  : write din when push and space is available (or a pop frees it)
//   pop        : drop head; ignored when empty
//   dout       : head entry, forced to 0 while empty
//   full, empty, count : occupancy, count ranges 0..DEPTH
module even_mult_rfifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/even_mult_driver.sv
// Batch initiator for the even multiplier core go/done/result handshake.
// Runs the core run_count times per start, queues each result in a FIFO
// that the consumer drains over res_valid/res_ready.
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   start, run_count  : begin a batch (sampled in IDLE only)
//   go_o              : one-cycle go pulse to the core per run
//   mult_done_i       : core done level; only a rising edge completes a run
//   mult_result_i     : core result, captured on done rising edge
//   res_data/valid/ready : FIFO head handshake to the consumer
//   busy              : FSM not in IDLE
//   all_done          : one-cycle pulse at batch end
//   err_timeout       : sticky watchdog flag
// Optional watchdog: define EVEN_MULT_DRIVER_TIMEOUT_EN; otherwise WAIT
// lasts until done rises and err_timeout is tied 0.
module even_mult_driver #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  run_count,
  output logic              go_o,
  input  logic              mult_done_i,
  input  logic [DATA_W-1:0] mult_result_i,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              all_done,
  output logic              err_timeout
);

  import even_mult_pkg::*;

  localparam int unsigned FC_W = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be nonzero");
  end

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   rem;
  logic [DATA_W-1:0]  hold;
  logic               done_q;
  logic               done_rise;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FC_W-1:0]    fifo_count;

`ifdef EVEN_MULT_DRIVER_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd;
  logic            wd_expired;
  logic            err_q;
  assign wd_expired  = (wd == WD_W'(TIMEOUT_CYC));
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  // done is a level that may still be high from the previous run, so only
  // a fresh low-to-high transition counts as completion.
  assign done_rise = mult_done_i & ~done_q;
  assign res_valid = ~fifo_empty;
  assign fifo_pop  = res_valid & res_ready;
  assign fifo_push = (state == STORE) & (~fifo_full | fifo_pop);
  assign busy      = (state != IDLE);

  even_mult_rfifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_rfifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (hold),
    .dout  (res_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rem    <= '0;
      hold   <= '0;
      done_q <= 1'b0;
`ifdef EVEN_MULT_DRIVER_TIMEOUT_EN
      wd     <= '0;
      err_q  <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      done_q <= mult_done_i;
      case (state)
        IDLE:  if (start) rem <= run_count;
        WAIT:  if (done_rise) hold <= mult_result_i;
        STORE: if (fifo_push) rem <= rem - 1'b1;
        default: ;
      endcase
`ifdef EVEN_MULT_DRIVER_TIMEOUT_EN
      if (state == GO) begin
        wd <= '0;
      end else if (state == WAIT) begin
        wd <= wd + 1'b1;
      end
      if (state == IDLE && start) begin
        err_q <= 1'b0;
      end else if (state == WAIT && !done_rise && wd_expired) begin
        err_q <= 1'b1;
        rem   <= '0;
      end
`endif
    end
  end

  always_comb begin
    state_nx = state;
    go_o     = 1'b0;
    all_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = (run_count == '0) ? FINISH : GO;
      end
      GO: begin
        go_o     = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        if (done_rise) begin
          state_nx = STORE;
        end
`ifdef EVEN_MULT_DRIVER_TIMEOUT_EN
        else if (wd_expired) begin
          state_nx = FINISH;
        end
`endif
      end
      STORE: begin
        if (fifo_push) state_nx = (rem == CNT_W'(1)) ? FINISH : GO;
      end
      FINISH: begin
        all_done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  a_fifo_count: assert property (@(posedge clk) disable iff (reset)
    fifo_count <= FC_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_even_mult_driver.sv
module tb_even_mult_driver;

  import even_mult_pkg::*;

  localparam int unsigned TO_CYC = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  run_count;
  logic        go_o;
  logic        mult_done_i;
  result_t     mult_result_i;
  result_t     res_data;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic        all_done;
  logic        err_timeout;

  always #5 clk = ~clk;

  even_mult_driver #(
    .DATA_W      (16),
    .FIFO_DEPTH  (4),
    .CNT_W       (8),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .run_count     (run_count),
    .go_o          (go_o),
    .mult_done_i   (mult_done_i),
    .mult_result_i (mult_result_i),
    .res_data      (res_data),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .busy          (busy),
    .all_done      (all_done),
    .err_timeout   (err_timeout)
  );

  int unsigned vec_cnt  = 0;
  int unsigned err_cnt  = 0;
  int unsigned go_cnt   = 0;
  int unsigned done_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] core_q[$];
  int unsigned lat      = 5;
  int unsigned hold_cyc = 0;
  int unsigned countdown;
  int unsigned hcnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] n);
    @(posedge clk);
    #1 start = 1'b1;
    run_count = n;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_all_done(input int unsigned budget, input string tag);
    int unsigned i = 0;
    while (done_cnt == 0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    tick(3);
    check_eq(tag, done_cnt, 1);
  endtask

  task automatic wait_drain(input int unsigned budget, input string tag);
    int unsigned i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    #1;
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic load(input logic [15:0] v);
    core_q.push_back(v);
    exp_q.push_back(v);
  endtask

  // Behavioural core: go drops done (after an optional hold), then done
  // rises with the next queued result after lat cycles; lat==0 never completes.
  initial begin
    mult_done_i   = 1'b0;
    mult_result_i = '0;
    countdown     = 0;
    hcnt          = 0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        countdown   = 0;
        hcnt        = 0;
        mult_done_i = 1'b0;
      end else if (go_o) begin
        countdown = lat;
        hcnt      = hold_cyc;
        if (hcnt == 0) mult_done_i = 1'b0;
      end else if (countdown > 0) begin
        if (hcnt > 0) begin
          hcnt--;
          if (hcnt == 0) mult_done_i = 1'b0;
        end
        countdown--;
        if (countdown == 0) begin
          mult_done_i   = 1'b1;
          mult_result_i = (core_q.size() != 0) ? core_q.pop_front() : 16'hBAD0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (go_o) go_cnt++;
      if (all_done) done_cnt++;
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_valid", res_valid, 0);
        end else begin
          check_eq("head", res_data, exp_q[0]);
          if (res_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck, expected completion");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    run_count = '0;
    res_ready = 1'b0;
    tick(3);
    check_eq("rst_go", go_o, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", res_valid, 0);
    check_eq("rst_all_done", all_done, 0);
    check_eq("rst_err", err_timeout, 0);
    check_eq("rst_data", res_data, 0);
    reset = 1'b0;
    tick(2);

    // 1: three runs, consumer always ready
    res_ready = 1'b1;
    lat = 5;
    go_cnt = 0; done_cnt = 0;
    load(16'h0002); load(16'h0008); load(16'h0030);
    launch(3);
    wait_all_done(100, "t1_all_done");
    wait_drain(20, "t1_drain");
    check_eq("t1_go_cnt", go_cnt, 3);
    check_eq("t1_busy", busy, 0);
    check_eq("t1_valid", res_valid, 0);

    // 2: empty batch goes straight to FINISH
    go_cnt = 0; done_cnt = 0;
    launch(0);
    check_eq("t2_all_done_hi", all_done, 1);
    check_eq("t2_busy_hi", busy, 1);
    tick(1);
    check_eq("t2_all_done_lo", all_done, 0);
    check_eq("t2_busy_lo", busy, 0);
    tick(2);
    check_eq("t2_go_cnt", go_cnt, 0);
    check_eq("t2_done_cnt", done_cnt, 1);
    check_eq("t2_valid", res_valid, 0);

    // 3: consumer stalled fills the FIFO; fifth result waits in STORE
    res_ready = 1'b0;
    lat = 3;
    go_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 6; i++) load(16'h0100 + 16'(i * 3));
    launch(6);
    tick(60);
    check_eq("t3_go_stalled", go_cnt, 5);
    check_eq("t3_busy", busy, 1);
    check_eq("t3_valid", res_valid, 1);
    check_eq("t3_queued", exp_q.size(), 6);
    tick(20);
    check_eq("t3_no_reissue", go_cnt, 5);
    check_eq("t3_no_finish", done_cnt, 0);
    res_ready = 1'b1;
    wait_all_done(100, "t3_all_done");
    wait_drain(20, "t3_drain");
    check_eq("t3_go_cnt", go_cnt, 6);

    // 4: done level held high into each new run
    lat = 6;
    hold_cyc = 2;
    mult_done_i = 1'b1;
    mult_result_i = 16'hDEAD;
    go_cnt = 0; done_cnt = 0;
    load(16'h0AAA); load(16'h0BBB); load(16'h0CCC);
    launch(3);
    wait_all_done(100, "t4_all_done");
    wait_drain(20, "t4_drain");
    check_eq("t4_go_cnt", go_cnt, 3);
    hold_cyc = 0;

    // 5: reset in WAIT of run 2 with one result queued
    res_ready = 1'b0;
    lat = 8;
    go_cnt = 0; done_cnt = 0;
    load(16'h1111); load(16'h2222); load(16'h3333);
    launch(3);
    for (int i = 0; i < 50 && go_cnt < 2; i++) @(posedge clk);
    tick(2);
    check_eq("t5_reached_run2", go_cnt, 2);
    check_eq("t5_one_queued", res_valid, 1);
    check_eq("t5_busy_pre", busy, 1);
    reset = 1'b1;
    exp_q.delete();
    core_q.delete();
    tick(1);
    check_eq("t5_go_after_rst", go_o, 0);
    check_eq("t5_valid_after_rst", res_valid, 0);
    check_eq("t5_busy_after_rst", busy, 0);
    reset = 1'b0;
    tick(1);
    res_ready = 1'b1;
    lat = 4;
    go_cnt = 0; done_cnt = 0;
    load(16'h4444); load(16'h5555);
    launch(2);
    wait_all_done(100, "t5_all_done");
    wait_drain(20, "t5_drain");
    check_eq("t5_go_cnt", go_cnt, 2);

    // 6: core never completes
    lat = 0;
    go_cnt = 0; done_cnt = 0;
    launch(2);
`ifdef EVEN_MULT_DRIVER_TIMEOUT_EN
    wait_all_done(60, "t6_timeout_finish");
    check_eq("t6_err_set", err_timeout, 1);
    check_eq("t6_go_cnt", go_cnt, 1);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_valid", res_valid, 0);
    launch(0);
    check_eq("t6_err_cleared", err_timeout, 0);
    tick(3);
`else
    tick(60);
    check_eq("t6_err_tied", err_timeout, 0);
    check_eq("t6_busy_hung", busy, 1);
    check_eq("t6_no_finish", done_cnt, 0);
    check_eq("t6_go_cnt", go_cnt, 1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check_eq("t6_busy_after_rst", busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
